// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-memory arbiter bus: I/D cache fill and store requests plus the memory port.
interface cache_mem_arbiter_if;
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        dcache_wr_req;
    logic [15:0] dcache_wr_addr;
    logic [15:0] dcache_wr_data;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;

    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic [15:0] fill_data;
    logic        icache_data_valid;
    logic        dcache_data_valid;
    logic [2:0]  fill_word;
    logic        icache_fill_done;
    logic        dcache_fill_done;
    logic        dcache_wr_ack;
    logic        icache_stall;
    logic        dcache_stall;

    // Caches and memory side
    modport master (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
               dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_data_in, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_data_out, fill_data,
               icache_data_valid, dcache_data_valid, fill_word,
               icache_fill_done, dcache_fill_done, dcache_wr_ack, icache_stall, dcache_stall
    );

    // Arbiter side
    modport slave (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
               dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_data_in, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_data_out, fill_data,
               icache_data_valid, dcache_data_valid, fill_word,
               icache_fill_done, dcache_fill_done, dcache_wr_ack, icache_stall, dcache_stall
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores onto one
// pipelined memory port; fills issue a full block of reads, then collect the returns.
module cache_mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    cache_mem_arbiter_if.slave bus
);
    localparam int unsigned ISSUE_W = $clog2(BLOCK_WORDS + 1);
    localparam int unsigned WORD_W  = $clog2(BLOCK_WORDS);
    localparam int unsigned AGE_W   = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DFILL = 2'd2,
        S_IFILL = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_base;
    logic [ISSUE_W-1:0] r_issue_cnt;
    logic [WORD_W-1:0]  r_ret_cnt;
    logic [AGE_W-1:0]   r_age;

    logic        w_fill;
    logic        w_issue;
    logic        w_ret;
    logic        w_last;
    logic        w_mem_enable;
    logic        w_mem_wr;
    logic [15:0] w_mem_addr;
    logic [15:0] w_mem_data_out;
    logic        w_icache_data_valid;
    logic        w_dcache_data_valid;
    logic        w_icache_fill_done;
    logic        w_dcache_fill_done;
    logic        w_dcache_wr_ack;

    assign w_fill  = (r_state == S_DFILL) || (r_state == S_IFILL);
    assign w_issue = w_fill && (r_issue_cnt < ISSUE_W'(BLOCK_WORDS));
    // A return earlier than MEM_LATENCY into a fill can only be a leftover of a burst dropped by reset
    assign w_ret   = w_fill && bus.mem_data_valid && (r_age >= AGE_W'(MEM_LATENCY));
    assign w_last  = w_ret && (r_ret_cnt == WORD_W'(BLOCK_WORDS - 1));

    // State, block base and burst counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_age       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
                r_age       <= '0;
                if (w_next == S_DFILL) begin
                    r_base <= bus.dcache_miss_addr & 16'hFFF0;
                end else if (w_next == S_IFILL) begin
                    r_base <= bus.icache_miss_addr & 16'hFFF0;
                end
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + ISSUE_W'(1);
                end
                if (w_ret) begin
                    r_ret_cnt <= r_ret_cnt + WORD_W'(1);
                end
                if (w_fill && (r_age < AGE_W'(MEM_LATENCY))) begin
                    r_age <= r_age + AGE_W'(1);
                end
            end
        end
    end

    // Next state and memory/cache strobes
    always_comb begin
        w_next              = r_state;
        w_mem_enable        = 1'b0;
        w_mem_wr            = 1'b0;
        w_mem_addr          = 16'h0000;
        w_mem_data_out      = 16'h0000;
        w_icache_data_valid = 1'b0;
        w_dcache_data_valid = 1'b0;
        w_icache_fill_done  = 1'b0;
        w_dcache_fill_done  = 1'b0;
        w_dcache_wr_ack     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.dcache_wr_req) begin
                    w_next = S_WRITE;
                end else if (bus.dcache_miss) begin
                    w_next = S_DFILL;
                end else if (bus.icache_miss) begin
                    w_next = S_IFILL;
                end
            end
            S_WRITE: begin
                w_mem_enable    = 1'b1;
                w_mem_wr        = 1'b1;
                w_mem_addr      = bus.dcache_wr_addr;
                w_mem_data_out  = bus.dcache_wr_data;
                w_dcache_wr_ack = 1'b1;
                w_next          = S_IDLE;
            end
            S_DFILL, S_IFILL: begin
                if (w_issue) begin
                    w_mem_enable = 1'b1;
                    // Word offset stays inside the 16-byte block
                    w_mem_addr   = r_base | 16'({r_issue_cnt[WORD_W-1:0], 1'b0});
                end
                w_dcache_data_valid = w_ret && (r_state == S_DFILL);
                w_icache_data_valid = w_ret && (r_state == S_IFILL);
                w_dcache_fill_done  = w_last && (r_state == S_DFILL);
                w_icache_fill_done  = w_last && (r_state == S_IFILL);
                if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.mem_enable        = w_mem_enable;
    assign bus.mem_wr            = w_mem_wr;
    assign bus.mem_addr          = w_mem_addr;
    assign bus.mem_data_out      = w_mem_data_out;
    assign bus.fill_data         = bus.mem_data_in;
    assign bus.fill_word         = 3'(r_ret_cnt);
    assign bus.icache_data_valid = w_icache_data_valid;
    assign bus.dcache_data_valid = w_dcache_data_valid;
    assign bus.icache_fill_done  = w_icache_fill_done;
    assign bus.dcache_fill_done  = w_dcache_fill_done;
    assign bus.dcache_wr_ack     = w_dcache_wr_ack;
    assign bus.icache_stall      = bus.icache_miss || (r_state == S_IFILL);
    assign bus.dcache_stall      = bus.dcache_miss || bus.dcache_wr_req ||
                                   (r_state == S_DFILL) || (r_state == S_WRITE);
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios then random traffic, checked each cycle
// against a transaction schedule model and a fixed-latency memory.
module tb_cache_mem_arbiter;
    localparam int LAT = 4;
    localparam int BW  = 8;

    typedef enum {M_NONE, M_WRITE, M_DFILL, M_IFILL} mop_t;
    typedef struct {
        int          due;
        logic [15:0] addr;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus();

    cache_mem_arbiter #(.MEM_LATENCY(LAT), .BLOCK_WORDS(BW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int          cyc, n_vec, n_bad;
    int          last_idone, last_ddone, last_ack, first_ivalid;
    int          n_ivalid, n_idone, n_issue, g, save;
    logic [15:0] last_issue_addr, salt;
    logic        armed, post_rst, seen_idone, seen_ddone, seen_ack;
    mop_t        m_op;
    int          m_start;
    logic [15:0] m_base;
    rd_t         pipe[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Start of a cycle: requesters retire completed requests, memory presents due data
    task automatic cyc_start();
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (seen_idone) bus.icache_miss   = 1'b0;
        if (seen_ddone) bus.dcache_miss   = 1'b0;
        if (seen_ack)   bus.dcache_wr_req = 1'b0;
        seen_idone = 1'b0;
        seen_ddone = 1'b0;
        seen_ack   = 1'b0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = 16'($urandom);
        while (pipe.size() > 0 && pipe[0].due < cyc) void'(pipe.pop_front());
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in    = mem_word(pipe[0].addr);
            void'(pipe.pop_front());
        end
    endtask

    // End of a cycle: compare against the schedule, advance memory and model
    task automatic cyc_end();
        logic        e_en, e_wr, e_ack, e_iv, e_dv, e_idn, e_ddn, e_ist, e_dst;
        logic [15:0] e_addr, e_dout, e_fd;
        logic [2:0]  e_fw;
        int          k;
        #1;
        e_en = 0; e_wr = 0; e_ack = 0; e_iv = 0; e_dv = 0; e_idn = 0; e_ddn = 0;
        e_addr = 16'h0; e_dout = 16'h0; e_fd = 16'h0; e_fw = 3'd0;
        k = cyc - m_start;
        case (m_op)
            M_WRITE: begin
                e_en = 1; e_wr = 1; e_ack = 1;
                e_addr = bus.dcache_wr_addr;
                e_dout = bus.dcache_wr_data;
            end
            M_DFILL, M_IFILL: begin
                if (k < BW) begin
                    e_en   = 1;
                    e_addr = m_base | 16'(2 * k);
                end
                if (k >= LAT && k < LAT + BW) begin
                    if (m_op == M_IFILL) e_iv = 1; else e_dv = 1;
                    e_fw = 3'(k - LAT);
                    e_fd = mem_word(m_base | 16'(2 * (k - LAT)));
                    if (k == LAT + BW - 1) begin
                        if (m_op == M_IFILL) e_idn = 1; else e_ddn = 1;
                    end
                end
            end
            default: ;
        endcase
        e_ist = bus.icache_miss || (m_op == M_IFILL);
        e_dst = bus.dcache_miss || bus.dcache_wr_req || (m_op == M_DFILL) || (m_op == M_WRITE);

        if (armed) begin
            chk("mem_enable", 16'(bus.mem_enable), 16'(e_en));
            chk("dcache_wr_ack", 16'(bus.dcache_wr_ack), 16'(e_ack));
            chk("icache_data_valid", 16'(bus.icache_data_valid), 16'(e_iv));
            chk("dcache_data_valid", 16'(bus.dcache_data_valid), 16'(e_dv));
            chk("icache_fill_done", 16'(bus.icache_fill_done), 16'(e_idn));
            chk("dcache_fill_done", 16'(bus.dcache_fill_done), 16'(e_ddn));
            chk("icache_stall", 16'(bus.icache_stall), 16'(e_ist));
            chk("dcache_stall", 16'(bus.dcache_stall), 16'(e_dst));
            chk("valid_exclusive", 16'(bus.icache_data_valid & bus.dcache_data_valid), 16'h0);
            if (e_en || post_rst) begin
                chk("mem_wr", 16'(bus.mem_wr), 16'(e_wr));
                chk("mem_addr", bus.mem_addr, e_addr);
            end
            if (e_wr || post_rst) chk("mem_data_out", bus.mem_data_out, e_dout);
            if (e_iv || e_dv || post_rst) chk("fill_word", 16'(bus.fill_word), 16'(e_fw));
            if (e_iv || e_dv) chk("fill_data", bus.fill_data, e_fd);

            if (bus.icache_fill_done === 1'b1) begin seen_idone = 1; last_idone = cyc; n_idone++; end
            if (bus.dcache_fill_done === 1'b1) begin seen_ddone = 1; last_ddone = cyc; end
            if (bus.dcache_wr_ack === 1'b1) begin seen_ack = 1; last_ack = cyc; end
            if (bus.icache_data_valid === 1'b1) begin
                n_ivalid++;
                if (first_ivalid < 0) first_ivalid = cyc;
            end
        end
        if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0) begin
            pipe.push_back('{due: cyc + LAT, addr: bus.mem_addr});
            n_issue++;
            last_issue_addr = bus.mem_addr;
        end

        post_rst = rst;
        if (rst) begin
            m_op = M_NONE;
        end else begin
            case (m_op)
                M_NONE: begin
                    if (bus.dcache_wr_req) begin
                        m_op = M_WRITE; m_start = cyc + 1;
                    end else if (bus.dcache_miss) begin
                        m_op = M_DFILL; m_start = cyc + 1; m_base = bus.dcache_miss_addr & 16'hFFF0;
                    end else if (bus.icache_miss) begin
                        m_op = M_IFILL; m_start = cyc + 1; m_base = bus.icache_miss_addr & 16'hFFF0;
                    end
                end
                M_WRITE: m_op = M_NONE;
                default: if (k == LAT + BW - 1) m_op = M_NONE;
            endcase
        end
        if (rst) armed = 1'b1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cyc_start();
            cyc_end();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        int budget;
        cyc = 0; n_vec = 0; n_bad = 0;
        last_idone = -1; last_ddone = -1; last_ack = -1; first_ivalid = -1;
        n_ivalid = 0; n_idone = 0; n_issue = 0; last_issue_addr = 16'h0;
        armed = 0; post_rst = 0; seen_idone = 0; seen_ddone = 0; seen_ack = 0;
        m_op = M_NONE; m_start = 0; m_base = 16'h0;
        salt = 16'($urandom);
        bus.icache_miss = 0; bus.icache_miss_addr = 16'h0;
        bus.dcache_miss = 0; bus.dcache_miss_addr = 16'h0;
        bus.dcache_wr_req = 0; bus.dcache_wr_addr = 16'h0; bus.dcache_wr_data = 16'h0;
        bus.mem_data_in = 16'h0; bus.mem_data_valid = 0;

        cyc_start(); rst = 1; cyc_end();
        run(2);

        // Lone I-miss at 0x1236
        n_ivalid = 0; n_issue = 0;
        cyc_start(); bus.icache_miss = 1; bus.icache_miss_addr = 16'h1236; g = cyc; cyc_end();
        run(14);
        chk("i_done_after_grant", 16'(last_idone - g), 16'd12);
        chk("i_valid_count", 16'(n_ivalid), 16'd8);
        chk("i_issue_count", 16'(n_issue), 16'd8);
        chk("i_last_addr", last_issue_addr, 16'h123E);

        // Simultaneous D and I misses: D first, I granted right after
        cyc_start();
        bus.dcache_miss = 1; bus.dcache_miss_addr = 16'h2468;
        bus.icache_miss = 1; bus.icache_miss_addr = 16'h8ABC;
        cyc_end();
        run(27);
        chk("i_after_d_done", 16'(last_idone - last_ddone), 16'd13);

        // Store with a D-miss: one write cycle, then the fill
        cyc_start();
        bus.dcache_wr_req = 1; bus.dcache_wr_addr = 16'h4000; bus.dcache_wr_data = 16'hBEEF;
        bus.dcache_miss = 1; bus.dcache_miss_addr = 16'h5550;
        g = cyc;
        cyc_end();
        run(16);
        chk("wr_ack_cycle", 16'(last_ack - g), 16'd1);
        chk("d_done_after_ack", 16'(last_ddone - last_ack), 16'd13);

        // I-miss arriving mid D fill waits for it
        first_ivalid = -1;
        cyc_start(); bus.dcache_miss = 1; bus.dcache_miss_addr = 16'h7A10; cyc_end();
        run(5);
        cyc_start(); bus.icache_miss = 1; bus.icache_miss_addr = 16'h0C0E; cyc_end();
        run(22);
        chk("i_first_valid_after_d", 16'(first_ivalid - last_ddone), 16'(2 + LAT));

        // Reset right after the third returned word
        save = n_idone; n_ivalid = 0;
        cyc_start(); bus.icache_miss = 1; bus.icache_miss_addr = 16'h3000; cyc_end();
        run(6);
        cyc_start(); rst = 1; bus.icache_miss = 0; cyc_end();
        chk("i_words_before_reset", 16'(n_ivalid), 16'd3);
        run(8);
        chk("no_done_after_reset", 16'(n_idone - save), 16'd0);
        cyc_start(); bus.icache_miss = 1; bus.icache_miss_addr = 16'h3002; g = cyc; cyc_end();
        run(14);
        chk("fresh_fill_done", 16'(last_idone - g), 16'd12);
        chk("fresh_fill_count", 16'(n_idone - save), 16'd1);

        // Top-of-memory block
        n_issue = 0;
        cyc_start(); bus.icache_miss = 1; bus.icache_miss_addr = 16'hFFF8; cyc_end();
        run(14);
        chk("top_issue_count", 16'(n_issue), 16'd8);
        chk("top_last_addr", last_issue_addr, 16'hFFFE);

        // Request withdrawn mid fill still completes
        save = n_idone;
        cyc_start(); bus.icache_miss = 1; bus.icache_miss_addr = 16'h0040; cyc_end();
        run(3);
        cyc_start(); bus.icache_miss = 0; cyc_end();
        run(12);
        chk("withdrawn_fill_done", 16'(n_idone - save), 16'd1);

        // Random traffic
        repeat (500) begin
            cyc_start();
            if (!bus.icache_miss && $urandom_range(0, 7) == 0) begin
                bus.icache_miss = 1; bus.icache_miss_addr = 16'($urandom);
            end
            if (!bus.dcache_miss && $urandom_range(0, 9) == 0) begin
                bus.dcache_miss = 1; bus.dcache_miss_addr = 16'($urandom);
            end
            if (!bus.dcache_wr_req && $urandom_range(0, 11) == 0) begin
                bus.dcache_wr_req = 1;
                bus.dcache_wr_addr = 16'($urandom);
                bus.dcache_wr_data = 16'($urandom);
            end
            cyc_end();
        end

        budget = 300;
        while ((bus.icache_miss || bus.dcache_miss || bus.dcache_wr_req || m_op != M_NONE) && budget > 0) begin
            run(1);
            budget--;
        end
        chk("drain_in_budget", 16'(budget == 0), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 4, SHALL be the cycles from a memory read issue to its mem_data_valid.
REQ-002 Parameter BLOCK_WORDS, default 8, SHALL be the 16-bit words per cache block; the block is 16 bytes.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 icache_miss  in  1  SHALL be the I-cache fill request, held high until icache_fill_done.
REQ-006 icache_miss_addr  in  16  SHALL be the I-cache miss byte address.
REQ-007 dcache_miss  in  1  SHALL be the D-cache fill request, held high until dcache_fill_done.
REQ-008 dcache_miss_addr  in  16  SHALL be the D-cache miss byte address.
REQ-009 dcache_wr_req  in  1  SHALL be the D-cache write-through store request, held high until dcache_wr_ack.
REQ-010 dcache_wr_addr / dcache_wr_data  in  16 / 16  SHALL be the store address and data.
REQ-011 mem_data_in  in  16  SHALL be the memory read data.
REQ-012 mem_data_valid  in  1  SHALL qualify mem_data_in.
REQ-013 mem_enable / mem_wr  out  1 / 1  SHALL be the memory access strobe and write select.
REQ-014 mem_addr / mem_data_out  out  16 / 16  SHALL be the memory address and write data.
REQ-015 fill_data  out  16  SHALL be mem_data_in passed combinationally.
REQ-016 icache_data_valid / dcache_data_valid  out  1 / 1  SHALL be mem_data_valid steered to the owning cache.
REQ-017 fill_word  out  3  SHALL be the word index of the current returned word.
REQ-018 icache_fill_done / dcache_fill_done / dcache_wr_ack  out  1 each  SHALL be one-cycle completion pulses.
REQ-019 icache_stall / dcache_stall  out  1 / 1  SHALL be high while that cache's request is pending or in service.

Function
REQ-020 The FSM SHALL have four states: IDLE, WRITE, DFILL and IFILL.
REQ-021 In IDLE, requests SHALL be granted by fixed priority: dcache_wr_req, then dcache_miss, then icache_miss.
REQ-022 A grant SHALL take effect on the next edge; a burst or write in progress SHALL never be preempted.
REQ-023 WRITE SHALL last one cycle, driving mem_enable=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_data_out=dcache_wr_data and dcache_wr_ack=1, then return to IDLE.
REQ-024 On fill entry, the block base SHALL be latched as {miss_addr[15:4],4'h0}.
REQ-025 The issue counter SHALL be reset to 0 on fill entry.
REQ-026 The return counter SHALL be reset to 0 on fill entry.
REQ-027 During a fill, the FSM SHALL issue one read per cycle for BLOCK_WORDS cycles: mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_count.
REQ-028 Address arithmetic SHALL be 16-bit, with no carry past bit 3 of the offset.
REQ-029 After issue_count reaches BLOCK_WORDS, mem_enable SHALL be 0.
REQ-030 Each mem_data_valid in a fill SHALL assert the owner's data_valid, output fill_word = return_count, and then increment return_count.
REQ-031 When the 8th word returns (return_count==7 with valid), the owner's fill_done SHALL pulse in that same cycle and the FSM SHALL return to IDLE.
REQ-032 Minimum fill occupancy SHALL be MEM_LATENCY+BLOCK_WORDS cycles (12 at defaults).
REQ-033 mem_data_valid in IDLE or WRITE SHALL be ignored: no data_valid and no counter change.
REQ-034 icache_data_valid and dcache_data_valid SHALL never be high together.
REQ-035 A request deasserting mid-service SHALL NOT abort the operation.
REQ-036 Simultaneous requests SHALL keep the losers' stalls high until they are served.

Reset
REQ-037 When rst=1 at an edge, the block SHALL enter IDLE and clear both counters and the base register.
REQ-038 All memory and control outputs SHALL be 0 next cycle, except stalls, which still reflect raw request inputs.
REQ-039 Reset mid-burst SHALL drop the burst with no fill_done; later stray mem_data_valid SHALL be ignored per REQ-033.

Verification
REQ-040 Bench SHALL cover: I-miss at 0x1236 alone -> mem_addr 0x1230,0x1232..0x123E over 8 cycles; 8 icache_data_valid with fill_word 0..7; icache_fill_done 12 cycles after grant.
REQ-041 Bench SHALL cover: dcache_miss and icache_miss raised in the same cycle -> D fill first; I fill granted the cycle after dcache_fill_done; icache_stall high throughout.
REQ-042 Bench SHALL cover: dcache_wr_req (0x4000, 0xBEEF) with dcache_miss -> one write cycle with mem_wr=1, then the D fill.
REQ-043 Bench SHALL cover: icache_miss raised during a D fill -> no preemption; no icache_data_valid until the D fill completes.
REQ-044 Bench SHALL cover: rst asserted after the 3rd returned word -> IDLE next cycle; outputs 0; no fill_done; a fresh miss then completes normally.
REQ-045 Bench SHALL cover: miss at 0xFFF8 -> addresses 0xFFF0..0xFFFE with no wrap past 0xFFFE.
